// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32 pipeline memory-access stage with req/ready data port and MEM/WB register
//
// Purpose:
//   Takes the EX/MEM pipeline register and drives a data-memory port. Stores
//   get lane-replicated data and byte enables. Loads are shifted, extended and
//   registered into MEM/WB. The stage stalls upstream while memory is busy and
//   abandons an access after TIMEOUT_CYCLES wait cycles (0 disables this).
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   MEM_*_i                        EX/MEM pipeline register contents
//   dmem_req_o/we_o/addr_o/
//   wdata_o/be_o                   data-memory request (combinational)
//   dmem_ready_i/rdata_i           memory completion and read word
//   MEM_stall_o                    freezes IF/ID/EX and EX/MEM registers
//   WB_*_o                         registered MEM/WB pipeline register
//   WB_misalign_o, WB_bus_err_o    one-cycle fault flags

module mem_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           MEM_pc_i,
    input  logic [DATA_WIDTH-1:0] MEM_alu_result_i,
    input  logic [DATA_WIDTH-1:0] MEM_rs2_data_i,
    input  logic [4:0]            MEM_rd_add_i,
    input  logic [1:0]            MEM_sel_to_reg_i,
    input  logic                  MEM_regwrite_i,
    input  logic                  MEM_RD_mem_i,
    input  logic                  MEM_WR_mem_i,
    input  logic [2:0]            MEM_mem_op_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [31:0]           dmem_addr_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    output logic [3:0]            dmem_be_o,
    input  logic                  dmem_ready_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic                  MEM_stall_o,
    output logic [31:0]           WB_pc_o,
    output logic [4:0]            WB_rd_add_o,
    output logic [1:0]            WB_sel_to_reg_o,
    output logic                  WB_regwrite_o,
    output logic [DATA_WIDTH-1:0] WB_alu_result_o,
    output logic [DATA_WIDTH-1:0] WB_mem_data_o,
    output logic                  WB_misalign_o,
    output logic                  WB_bus_err_o
);

    // Counter holds the number of cycles the current request has already waited.
    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [31:0]           wb_pc_q, wb_pc_d;
    logic [4:0]            wb_rd_q, wb_rd_d;
    logic [1:0]            wb_sel_q, wb_sel_d;
    logic                  wb_regwrite_q, wb_regwrite_d;
    logic [DATA_WIDTH-1:0] wb_alu_q, wb_alu_d;
    logic [DATA_WIDTH-1:0] wb_mem_data_q, wb_mem_data_d;
    logic                  wb_misalign_q, wb_misalign_d;
    logic                  wb_bus_err_q, wb_bus_err_d;

    logic                  access;
    logic                  misalign;
    logic                  req;
    logic                  timeout;
    logic                  stall;
    logic                  complete;
    logic [1:0]            lane;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0]            be;

    always_comb begin
        access   = MEM_RD_mem_i | MEM_WR_mem_i;
        lane     = MEM_alu_result_i[1:0];
        misalign = ((MEM_mem_op_i[1:0] == 2'b01) && lane[0]) ||
                   ((MEM_mem_op_i[1:0] == 2'b10) && (lane != 2'b00));

        // Gated by rst_n so an access in flight disappears the moment reset asserts.
        req = rst_n && (((state_q == S_IDLE) && access && !misalign) ||
                        (state_q == S_WAIT));

        timeout  = (TIMEOUT_CYCLES != 0) && req && !dmem_ready_i &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));
        stall    = req && !dmem_ready_i && !timeout;
        complete = req && dmem_ready_i;
    end

    // Store lane alignment; loads always read the full word.
    always_comb begin
        wdata = MEM_rs2_data_i;
        be    = 4'b1111;
        if (MEM_WR_mem_i) begin
            case (MEM_mem_op_i[1:0])
                2'b00: begin
                    wdata = {4{MEM_rs2_data_i[7:0]}};
                    be    = 4'b0001 << lane;
                end
                2'b01: begin
                    wdata = {2{MEM_rs2_data_i[15:0]}};
                    be    = 4'b0011 << lane;
                end
                default: begin
                    wdata = MEM_rs2_data_i;
                    be    = 4'b1111;
                end
            endcase
        end
    end

    // Load extraction: bring the addressed byte/half down to bit 0, then extend.
    always_comb begin
        shifted = dmem_rdata_i >> {lane, 3'b000};
        case (MEM_mem_op_i)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_data = {24'h000000, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_data = {16'h0000, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // FSM next state and wait counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req && !dmem_ready_i && !timeout) begin
                    state_d = S_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            S_WAIT: begin
                if (dmem_ready_i || timeout) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // MEM/WB next value.
    always_comb begin
        wb_pc_d       = wb_pc_q;
        wb_rd_d       = wb_rd_q;
        wb_sel_d      = wb_sel_q;
        wb_regwrite_d = wb_regwrite_q;
        wb_alu_d      = wb_alu_q;
        wb_mem_data_d = wb_mem_data_q;
        wb_misalign_d = 1'b0;
        wb_bus_err_d  = 1'b0;
        if (stall) begin
            // Bubble: nothing writes back, data fields keep their last value.
            wb_regwrite_d = 1'b0;
            wb_rd_d       = 5'd0;
        end else begin
            wb_pc_d       = MEM_pc_i;
            wb_rd_d       = MEM_rd_add_i;
            wb_sel_d      = MEM_sel_to_reg_i;
            wb_regwrite_d = MEM_regwrite_i;
            wb_alu_d      = MEM_alu_result_i;
            wb_mem_data_d = '0;
            if (access) begin
                if (misalign) begin
                    wb_regwrite_d = 1'b0;
                    wb_misalign_d = 1'b1;
                end else if (complete) begin
                    if (!MEM_WR_mem_i) begin
                        wb_mem_data_d = load_data;
                    end
                end else begin
                    // Only remaining unstalled case for an aligned access is a timeout.
                    wb_regwrite_d = 1'b0;
                    wb_bus_err_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            wb_pc_q       <= '0;
            wb_rd_q       <= '0;
            wb_sel_q      <= '0;
            wb_regwrite_q <= 1'b0;
            wb_alu_q      <= '0;
            wb_mem_data_q <= '0;
            wb_misalign_q <= 1'b0;
            wb_bus_err_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wb_pc_q       <= wb_pc_d;
            wb_rd_q       <= wb_rd_d;
            wb_sel_q      <= wb_sel_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_alu_q      <= wb_alu_d;
            wb_mem_data_q <= wb_mem_data_d;
            wb_misalign_q <= wb_misalign_d;
            wb_bus_err_q  <= wb_bus_err_d;
        end
    end

    assign dmem_req_o      = req;
    assign dmem_we_o       = req && MEM_WR_mem_i;
    assign dmem_addr_o     = {MEM_alu_result_i[31:2], 2'b00};
    assign dmem_wdata_o    = wdata;
    assign dmem_be_o       = be;
    assign MEM_stall_o     = stall;
    assign WB_pc_o         = wb_pc_q;
    assign WB_rd_add_o     = wb_rd_q;
    assign WB_sel_to_reg_o = wb_sel_q;
    assign WB_regwrite_o   = wb_regwrite_q;
    assign WB_alu_result_o = wb_alu_q;
    assign WB_mem_data_o   = wb_mem_data_q;
    assign WB_misalign_o   = wb_misalign_q;
    assign WB_bus_err_o    = wb_bus_err_q;

endmodule
